// File: rtl/minx16_fetch_pkg.sv
// ============================================================================
// Module   : minx16_fetch_pkg
// Brief    : Shared types and default widths for the Minx16 fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package minx16_fetch_pkg;

    localparam int FETCH_W     = 16;
    localparam int FETCH_AW    = 16;
    localparam int FETCH_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/minx16_fetch_fifo.sv
// ============================================================================
// Module   : minx16_fetch_fifo
// Brief    : DEPTH-entry synchronous FIFO; flush overrides push and pop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module minx16_fetch_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [CW-1:0] count_o,
    output logic [DW-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_en;
    logic          pop_en;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push_en = push_i && (count_q < CW'(DEPTH));
    assign pop_en  = pop_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_en) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/minx16_fetch_unit.sv
// ============================================================================
// Module   : minx16_fetch_unit
// Brief    : Minx16 instruction fetch: one outstanding read, tagged FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module minx16_fetch_unit
    import minx16_fetch_pkg::*;
#(
    parameter int W     = FETCH_W,
    parameter int AW    = FETCH_AW,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_q,
    output logic          pc_inc,
    output logic          pc_ld,
    output logic [AW-1:0] pc_d,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic          imem_rvalid,
    input  logic [W-1:0]  imem_rdata,
    input  logic          redir_valid,
    input  logic [AW-1:0] redir_addr,
    output logic          ir_valid,
    output logic [W-1:0]  ir_data,
    output logic [AW-1:0] ir_pc,
    input  logic          ir_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [AW-1:0]   req_pc_q;
    logic [AW-1:0]   req_pc_d;
    logic [CW-1:0]   fifo_count;
    logic [W+AW-1:0] fifo_head;
    logic            push;
    logic            pop;
    logic            accept;
    logic [CW:0]     count_after;
    logic            slot_free;

    assign push        = (state_q == WAIT) && imem_rvalid && !redir_valid;
    assign pop         = ir_valid && ir_ready;
    assign count_after = {1'b0, fifo_count} + (CW+1)'(push) - (CW+1)'(pop);
    assign slot_free   = count_after < (CW+1)'(DEPTH);

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            IDLE: if (slot_free) state_d = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (imem_ready) state_d = WAIT;
            end
            WAIT: if (imem_rvalid) state_d = slot_free ? REQ : IDLE;
            DROP: if (imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A read still in flight after a redirect must be absorbed in DROP.
        if (redir_valid) begin
            imem_req = 1'b0;
            if (((state_q == WAIT) || (state_q == DROP)) && !imem_rvalid) begin
                state_d = DROP;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign accept   = imem_req && imem_ready;
    assign req_pc_d = accept ? pc_q : req_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    minx16_fetch_fifo #(
        .DW    (W + AW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redir_valid),
        .push_i      (push),
        .push_data_i ({imem_rdata, req_pc_q}),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign pc_inc    = accept;
    assign pc_ld     = redir_valid;
    assign pc_d      = redir_addr;
    assign imem_addr = pc_q;
    assign ir_valid  = (fifo_count != '0);
    assign ir_data   = fifo_head[W+AW-1:AW];
    assign ir_pc     = fifo_head[AW-1:0];

endmodule

`default_nettype wire

// File: tb/tb_minx16_fetch_unit.sv
// ============================================================================
// Module   : tb_minx16_fetch_unit
// Brief    : Directed bench: PC model and 2-cycle memory folded into tick().
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_minx16_fetch_unit;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic [15:0] pc_q;
    logic        pc_inc;
    logic        pc_ld;
    logic [15:0] pc_d;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redir_valid;
    logic [15:0] redir_addr;
    logic        ir_valid;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic        ir_ready;

    int          checks;
    int          failures;
    int          mem_cnt;
    logic [15:0] mem_addr;

    minx16_fetch_unit #(
        .W     (16),
        .AW    (16),
        .DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_q        (pc_q),
        .pc_inc      (pc_inc),
        .pc_ld       (pc_ld),
        .pc_d        (pc_d),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .ir_valid    (ir_valid),
        .ir_data     (ir_data),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the PC register and memory respond to what the
    // DUT did during the cycle just ending. Memory data = address + 0x1234.
    task automatic tick();
        logic        acc, inc, ld, r;
        logic [15:0] ldv, a;
        #1;
        assert (!(imem_rvalid && imem_req))
        else begin
            failures++;
            $error("FAIL protocol rvalid_with_req observed=1 expected=0");
        end
        acc = imem_req && imem_ready;
        inc = pc_inc;
        ld  = pc_ld;
        ldv = pc_d;
        a   = imem_addr;
        r   = rst;
        @(posedge clk);
        #1;
        if (r)        pc_q = 16'h0000;
        else if (ld)  pc_q = ldv;
        else if (inc) pc_q = pc_q + 16'h0002;
        imem_rvalid = 1'b0;
        if (mem_cnt != 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_addr + 16'h1234;
            end
        end
        if (acc) begin
            mem_cnt  = LAT - 1;
            mem_addr = a;
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        mem_cnt     = 0;
        mem_addr    = '0;
        rst         = 1'b1;
        pc_q        = '0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redir_valid = 1'b0;
        redir_addr  = '0;
        ir_ready    = 1'b0;

        tick(); tick(); #1;
        chk("rst_req", imem_req, 0);
        chk("rst_inc", pc_inc, 0);
        chk("rst_irv", ir_valid, 0);
        chk("rst_ird", ir_data, 0);
        chk("rst_irpc", ir_pc, 0);

        // cycle 0: reset released
        rst = 1'b0; #1;
        chk("c0_idle", imem_req, 0);
        tick(); #1;                                  // cycle 1
        chk("c1_req", imem_req, 1);
        chk("c1_inc", pc_inc, 1);
        chk("c1_addr", imem_addr, 16'h0000);
        tick(); #1;                                  // cycle 2
        chk("c2_wait", imem_req, 0);
        tick(); #1;                                  // cycle 3
        chk("c3_novalid", ir_valid, 0);
        tick(); #1;                                  // cycle 4
        chk("c4_irv", ir_valid, 1);
        chk("c4_ird", ir_data, 16'h1234);
        chk("c4_irpc", ir_pc, 16'h0000);
        chk("c4_req", imem_req, 1);
        chk("c4_addr", imem_addr, 16'h0002);
        tick(); tick(); tick();                      // cycle 7: full

        for (int i = 7; i < 13; i++) begin
            #1;
            chk("full_noreq", imem_req, 0);
            chk("full_head", ir_pc, 16'h0000);
            tick();
        end

        // cycle 13: first pop
        ir_ready = 1'b1; #1;
        chk("c13_noreq", imem_req, 0);
        tick(); ir_ready = 1'b0; #1;                 // cycle 14
        chk("c14_ird", ir_data, 16'h1236);
        chk("c14_irpc", ir_pc, 16'h0002);
        chk("c14_req", imem_req, 1);
        chk("c14_addr", imem_addr, 16'h0004);
        tick(); tick(); tick(); #1;                  // cycle 17: full again
        chk("c17_noreq", imem_req, 0);
        ir_ready = 1'b1;
        tick(); ir_ready = 1'b0; #1;                 // cycle 18
        chk("c18_irpc", ir_pc, 16'h0004);
        chk("c18_addr", imem_addr, 16'h0006);

        // cycle 19: redirect in WAIT with one entry buffered
        tick(); redir_valid = 1'b1; redir_addr = 16'h0100; #1;
        chk("c19_ld", pc_ld, 1);
        chk("c19_pcd", pc_d, 16'h0100);
        chk("c19_req", imem_req, 0);
        chk("c19_irv", ir_valid, 1);
        tick(); redir_valid = 1'b0; #1;              // cycle 20: DROP
        chk("c20_flush", ir_valid, 0);
        chk("c20_req", imem_req, 0);
        tick(); #1;                                  // cycle 21
        chk("c21_dropped", ir_valid, 0);
        chk("c21_req", imem_req, 0);
        tick(); #1;                                  // cycle 22
        chk("c22_req", imem_req, 1);
        chk("c22_addr", imem_addr, 16'h0100);
        tick(); tick(); tick(); #1;                  // cycle 25
        chk("c25_irv", ir_valid, 1);
        chk("c25_irpc", ir_pc, 16'h0100);
        chk("c25_ird", ir_data, 16'h1334);
        chk("c25_addr", imem_addr, 16'h0102);

        // cycle 27: redirect together with rvalid and pop
        tick(); tick();
        ir_ready = 1'b1; redir_valid = 1'b1; redir_addr = 16'h0200; #1;
        chk("c27_rv", imem_rvalid, 1);
        chk("c27_req", imem_req, 0);
        tick(); ir_ready = 1'b0; redir_valid = 1'b0; #1;   // cycle 28
        chk("c28_empty", ir_valid, 0);
        chk("c28_req", imem_req, 0);

        // cycles 29-33: memory not ready, redirect in cycle 31
        tick(); imem_ready = 1'b0; #1;               // cycle 29
        chk("c29_req", imem_req, 1);
        chk("c29_addr", imem_addr, 16'h0200);
        chk("c29_inc", pc_inc, 0);
        tick(); #1;                                  // cycle 30
        chk("c30_addr", imem_addr, 16'h0200);
        chk("c30_inc", pc_inc, 0);
        tick(); redir_valid = 1'b1; redir_addr = 16'h0300; #1;   // cycle 31
        chk("c31_withdraw", imem_req, 0);
        chk("c31_inc", pc_inc, 0);
        tick(); redir_valid = 1'b0; #1;              // cycle 32
        chk("c32_req", imem_req, 0);
        tick(); #1;                                  // cycle 33
        chk("c33_req", imem_req, 1);
        chk("c33_addr", imem_addr, 16'h0300);
        chk("c33_inc", pc_inc, 0);
        tick(); imem_ready = 1'b1; #1;               // cycle 34
        chk("c34_inc", pc_inc, 1);
        tick(); tick(); tick(); #1;                  // cycle 37
        chk("c37_irv", ir_valid, 1);
        chk("c37_irpc", ir_pc, 16'h0300);
        chk("c37_ird", ir_data, 16'h1534);
        chk("c37_addr", imem_addr, 16'h0302);

        // cycle 38: reset while the 0x0302 read is outstanding
        tick(); rst = 1'b1; #1;
        tick(); rst = 1'b0; #1;                      // cycle 39: late rvalid
        chk("c39_rv", imem_rvalid, 1);
        chk("c39_irv", ir_valid, 0);
        chk("c39_ird", ir_data, 0);
        chk("c39_irpc", ir_pc, 0);
        chk("c39_req", imem_req, 0);
        tick(); #1;                                  // cycle 40
        chk("c40_irv", ir_valid, 0);
        chk("c40_req", imem_req, 1);
        chk("c40_addr", imem_addr, 16'h0000);
        tick(); #1;                                  // cycle 41
        chk("c41_irv", ir_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/minx16_fetch_unit.md
# minx16_fetch_unit

Instruction fetch stage of the Minx16 core, directly downstream of the program counter. It takes the PC value, issues one instruction-memory read at a time, and advances the PC by one word when each read is accepted. Returned instructions, tagged with their address, are buffered in a small FIFO for decode. A redirect from execute flushes the FIFO, discards any in-flight read and reloads the PC.

## Interface
- `W`, default 16: instruction/data width; PC step per fetch is W/8 bytes, applied by the PC.
- `AW`, default 16: address width.
- `DEPTH`, default 2: instruction FIFO entries (≥2).

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `pc_q`  in  AW: current PC value.
- `pc_inc`  out  1: advance PC; pulses on each accepted memory request.
- `pc_ld`  out  1: load PC; equals `redir_valid`.
- `pc_d`  out  AW: PC load value; equals `redir_addr`.
- `imem_req`  out  1: read request.
- `imem_addr`  out  AW: request address; equals `pc_q`, meaningful while `imem_req`=1.
- `imem_ready`  in  1: request accepted this cycle when `imem_req`&`imem_ready`.
- `imem_rvalid`  in  1: read data valid; one pulse per accepted request, latency ≥1 cycle.
- `imem_rdata`  in  W: read data.
- `redir_valid`  in  1: one-cycle redirect/flush.
- `redir_addr`  in  AW: redirect target.
- `ir_valid`  out  1: FIFO head valid.
- `ir_data`  out  W: head instruction.
- `ir_pc`  out  AW: head instruction address.
- `ir_ready`  in  1: decode pops head when `ir_valid`&`ir_ready`.

## Operation
- FSM states: IDLE, REQ, WAIT, DROP. Reset → IDLE.
- IDLE: go to REQ when the FIFO has a free slot (`count < DEPTH`, evaluated after this cycle's pop).
- REQ: `imem_req`=1. Hold address stable until accepted. On acceptance: `pc_inc`=1, latch `pc_q` into `req_pc`, go to WAIT.
- WAIT: on `imem_rvalid`, push {`imem_rdata`, `req_pc`}. Then go to REQ if a slot remains after the push/pop, else IDLE.
- DROP: the outstanding response is discarded. On `imem_rvalid`, go to IDLE (no push).
- At most one outstanding read. A request is only issued with a FIFO slot reserved, so a push never overflows.
- Redirect (`redir_valid`=1), highest priority:
  - `imem_req` forced 0 and `pc_inc` forced 0 that cycle.
  - FIFO flushed; any simultaneous pop or push is ignored.
  - From WAIT with no `imem_rvalid` that cycle, go to DROP. Otherwise go to IDLE.
  - A REQ not yet accepted is withdrawn; this is the only permitted withdrawal.
- PC arithmetic and wrap are owned by the PC. The fetch unit passes addresses unmodified; address wrap is transparent.
- `imem_rvalid` in IDLE or REQ is protocol error: ignored, flagged by bench assertion.

## Timing
- Reset values: `imem_req` 0, `pc_inc` 0, `ir_valid` 0, `ir_data` 0, `ir_pc` 0, FIFO count 0, `req_pc` 0. `pc_ld`/`pc_d` follow the redirect inputs.
- First request is asserted 1 cycle after `rst` is deasserted (IDLE→REQ).
- `pc_inc` pulses in the acceptance cycle N; `pc_q` is new in N+1 and used for the next request.
- `imem_rvalid` in cycle M makes `ir_valid`=1 in M+1 (registered FIFO). The next request is asserted in M+1.
- Steady-state throughput: one instruction per (memory latency + 1) cycles with 1-cycle ready.
- FIFO full with pop and no push: space frees the same cycle, so IDLE→REQ is allowed.
- A push into an empty FIFO with a simultaneous `ir_ready` does not bypass; the head is visible in the next cycle.
- `rst` asserted mid-operation: everything returns to reset values next cycle. A late response after reset is ignored because the FSM is in IDLE.

## Structure
- Package `minx16_fetch_pkg`: FSM state enum `fetch_state_t` (IDLE, REQ, WAIT, DROP) and the default width constants.
- Sub-module `minx16_fetch_fifo`: parameterised DEPTH×(W+AW) synchronous FIFO.
  - Ports: push, pop, flush, count, head data.
  - Flush has priority over push and pop.
- FSM, `req_pc` register and redirect gating live in the top module.

## Test plan
- **Reset and first fetch:** `pc_q`=0x0000, `imem_ready`=1, 2-cycle latency, `rdata`=0x1234 → `imem_req` at cycle 1, `pc_inc` pulse at cycle 1, `ir_valid` with `ir_data`=0x1234 / `ir_pc`=0x0000 at cycle 4.
- **Stream with backpressure:** `ir_ready`=0 for 10 cycles → exactly DEPTH=2 entries fetched (0x0000, 0x0002). `imem_req` stays low while full and resumes 1 cycle after the first pop.
- **Redirect while in WAIT:** redirect to 0x0100 → `pc_ld`=1 / `pc_d`=0x0100 that cycle, FIFO empty next cycle, the in-flight response is not pushed, and the next request is at 0x0100 with `ir_pc`=0x0100.
- **Redirect in the same cycle as `imem_rvalid` and a pop:** data dropped, FIFO empty, FSM goes to IDLE then REQ; no DROP state entered.
- **Unaccepted request:** `imem_ready`=0 for 5 cycles → `imem_addr` stable, `pc_inc` stays 0. A redirect in cycle 3 withdraws `imem_req` for 1 cycle; the next request is at the new address.
- **Reset mid-WAIT:** assert `rst` 1 cycle, then deliver a late `imem_rvalid` → ignored, `ir_valid` stays 0, `imem_req` resumes 1 cycle after reset release.
